// File: rtl/audio_adc_deserializer_pkg.sv
// Shared definitions for the codec ADC deserializer: default widths, FSM states
// and the sign-extension helper used when publishing samples.
package audio_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int SAMPLE_BITS_DEF = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // Replicates bit (bits-1) of w into every higher position; bits is elaboration-constant.
  function automatic logic [63:0] sext(input logic [63:0] w, input int bits);
    logic [63:0] result;
    logic        sign_bit;
    sign_bit = w[6'(bits - 1)];
    for (int i = 0; i < 64; i++) begin
      result[i] = (i < bits) ? w[i] : sign_bit;
    end
    return result;
  endfunction

endpackage

// File: rtl/audio_adc_deserializer_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with one-cycle rise/fall pulses
// derived from the synchronized value.
module sync_edge (
  input  logic CLK,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_q    = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/audio_adc_deserializer.sv
// I2S ADC stream receiver: synchronizes BCLK/LRCK/DAT into CLK, deframes left/right
// words and publishes a sign-extended stereo pair with a one-cycle ready strobe.
module audio_adc_deserializer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] sample_l,
  output logic [DATA_WIDTH-1:0] sample_r,
  output logic                  audio_ready,
  output logic                  frame_err
);

  localparam int CW = $clog2(SAMPLE_BITS + 1);

  logic w_bclk_q, w_bclk_rise, w_bclk_fall;
  logic w_lr_q, w_lr_rise, w_lr_fall;
  logic w_lr_edge;
  logic r_dat_meta, r_dat_sync;

  sync_edge u_sync_bclk (
    .CLK(CLK), .rst(rst), .i_d(AUD_BCLK),
    .o_q(w_bclk_q), .o_rise(w_bclk_rise), .o_fall(w_bclk_fall)
  );

  sync_edge u_sync_lrck (
    .CLK(CLK), .rst(rst), .i_d(AUD_ADCLRCK),
    .o_q(w_lr_q), .o_rise(w_lr_rise), .o_fall(w_lr_fall)
  );

  // Data path has the same depth as the clock synchronizers so bits line up with the rise pulse.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_dat_meta <= 1'b0;
      r_dat_sync <= 1'b0;
    end else begin
      r_dat_meta <= AUD_ADCDAT;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign w_lr_edge = w_lr_rise | w_lr_fall;

  state_t                 r_state, w_state_next;
  logic                   r_chan;
  logic [CW-1:0]          r_cnt;
  logic [SAMPLE_BITS-1:0] r_shift;
  logic [SAMPLE_BITS-1:0] r_left_buf;
  logic [SAMPLE_BITS-1:0] r_right_buf;
  logic                   r_left_valid;
  logic                   r_pair_pend;
  logic                   r_ready;
  logic                   r_frame_err;
  logic [DATA_WIDTH-1:0]  r_sample_l, r_sample_r;
  logic                   w_err_next, w_shift_en, w_done;
  logic [SAMPLE_BITS-1:0] w_word;

  assign w_word = {r_shift[SAMPLE_BITS-2:0], r_dat_sync};

  // An LRCK edge always wins over a coincident BCLK rise: that rise is the delay bit.
  always_comb begin
    w_state_next = r_state;
    w_err_next   = 1'b0;
    w_shift_en   = 1'b0;
    w_done       = 1'b0;
    if (!en) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (w_lr_edge) w_state_next = SKIP;
        SKIP:  if (!w_lr_edge && w_bclk_rise) w_state_next = SHIFT;
        SHIFT: begin
          if (w_lr_edge) begin
            w_err_next   = 1'b1;
            w_state_next = SKIP;
          end else if (w_bclk_rise) begin
            w_shift_en = 1'b1;
            if (r_cnt == CW'(SAMPLE_BITS - 1)) begin
              w_done       = 1'b1;
              w_state_next = WAIT;
            end
          end
        end
        WAIT:  if (w_lr_edge) w_state_next = SKIP;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_chan       <= 1'b0;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_left_buf   <= '0;
      r_right_buf  <= '0;
      r_left_valid <= 1'b0;
      r_pair_pend  <= 1'b0;
      r_ready      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_sample_l   <= '0;
      r_sample_r   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_frame_err <= w_err_next;
      r_ready     <= 1'b0;
      if (!en) begin
        r_left_valid <= 1'b0;
        r_pair_pend  <= 1'b0;
      end else begin
        if (w_lr_edge) begin
          r_chan  <= w_lr_q;
          r_cnt   <= '0;
          r_shift <= '0;
        end
        if (w_err_next) r_left_valid <= 1'b0;
        if (w_shift_en) begin
          r_shift <= w_word;
          r_cnt   <= r_cnt + CW'(1);
        end
        if (w_done) begin
          if (!r_chan) begin
            r_left_buf   <= w_word;
            r_left_valid <= 1'b1;
          end else if (r_left_valid) begin
            r_right_buf  <= w_word;
            r_pair_pend  <= 1'b1;
            r_left_valid <= 1'b0;
          end
        end
        if (r_pair_pend) begin
          r_sample_l  <= DATA_WIDTH'(sext(64'(r_left_buf), SAMPLE_BITS));
          r_sample_r  <= DATA_WIDTH'(sext(64'(r_right_buf), SAMPLE_BITS));
          r_ready     <= 1'b1;
          r_pair_pend <= 1'b0;
        end
      end
    end
  end

  assign sample_l    = r_sample_l;
  assign sample_r    = r_sample_r;
  assign audio_ready = r_ready & en;
  assign frame_err   = r_frame_err & en;

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Drives an I2S ADC stream (BCLK = CLK/8, 32-bit slots) into the deserializer and
// checks each published stereo pair against a queue of expected pairs.
module tb_audio_adc_deserializer;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        bclk = 1'b0;
  logic        lrck = 1'b1;
  logic        dat = 1'b0;
  logic [31:0] sample_l, sample_r;
  logic        audio_ready, frame_err;

  int checks = 0;
  int errors = 0;
  int n_strobes = 0;
  int n_ferr = 0;
  int ferr_run = 0;
  logic [63:0] exp_q[$];

  always #5 CLK = ~CLK;

  audio_adc_deserializer #(.DATA_WIDTH(32), .SAMPLE_BITS(24)) dut (
    .CLK(CLK), .rst(rst), .en(en),
    .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
    .sample_l(sample_l), .sample_r(sample_r),
    .audio_ready(audio_ready), .frame_err(frame_err)
  );

  // Scoreboard: every strobe pops one expected pair.
  always @(negedge CLK) begin
    logic [63:0] e;
    if (audio_ready) begin
      n_strobes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got L=%h R=%h, required no strobe", sample_l, sample_r);
      end else begin
        e = exp_q.pop_front();
        if ({sample_l, sample_r} !== e) begin
          errors++;
          $display("FAIL pair_data: got L=%h R=%h, required L=%h R=%h",
                   sample_l, sample_r, e[63:32], e[31:0]);
        end else begin
          $display("strobe %0d: L=%h R=%h ok", n_strobes, sample_l, sample_r);
        end
      end
    end
    if (frame_err) begin
      n_ferr++;
      ferr_run++;
    end else if (ferr_run != 0) begin
      checks++;
      if (ferr_run != 1) begin
        errors++;
        $display("FAIL frame_err_width: got %0d cycles, required 1", ferr_run);
      end
      ferr_run = 0;
    end
  end

  function automatic logic [31:0] sx24(input logic [23:0] w);
    return {{8{w[23]}}, w};
  endfunction

  task automatic send_bit(input logic lr, input logic d);
    lrck = lr;
    dat  = d;
    #40 bclk = 1'b1;
    #40 bclk = 1'b0;
  endtask

  // One channel slot: delay bit, nbits MSB-first, then optional padding to 32 BCLKs.
  task automatic send_word(input logic lr, input logic [23:0] w, input int nbits, input bit pad);
    send_bit(lr, 1'($urandom_range(0, 1)));
    for (int i = 0; i < nbits; i++) send_bit(lr, w[23-i]);
    if (pad) for (int i = nbits + 1; i < 32; i++) send_bit(lr, 1'b0);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input bit expect_pair);
    if (expect_pair) exp_q.push_back({sx24(l), sx24(r)});
    send_word(1'b0, l, 24, 1'b1);
    send_word(1'b1, r, 24, 1'b1);
  endtask

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end else begin
      $display("check %s: %h ok", name, got);
    end
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b0;
    #30;
    check_eq("reset_sample_l", sample_l, 32'h0);
    check_eq("reset_sample_r", sample_r, 32'h0);
    check_eq("reset_ready", {31'h0, audio_ready}, 32'h0);
    check_eq("reset_frame_err", {31'h0, frame_err}, 32'h0);
    rst = 1'b1;
    #40;
  endtask

  task automatic test_single_frame();
    int s0, f0;
    s0 = n_strobes;
    f0 = n_ferr;
    send_frame(24'h123456, 24'hFEDCBA, 1'b1);
    check_eq("single_strobes", 32'(n_strobes - s0), 32'd1);
    check_eq("single_sample_l", sample_l, 32'h00123456);
    check_eq("single_sample_r", sample_r, 32'hFFFEDCBA);
    check_eq("single_no_frame_err", 32'(n_ferr - f0), 32'd0);
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = n_strobes;
    for (int k = 0; k < 100; k++)
      send_frame(24'($urandom), 24'($urandom), 1'b1);
    check_eq("b2b_strobes", 32'(n_strobes - s0), 32'd100);
    check_eq("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_mid_right_start();
    int s0;
    rst  = 1'b0;
    lrck = 1'b1;
    #40;
    rst = 1'b1;
    #40;
    s0 = n_strobes;
    for (int i = 0; i < 14; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    check_eq("midright_no_strobe", 32'(n_strobes - s0), 32'd0);
    send_frame(24'h7FFFFF, 24'h800000, 1'b1);
    check_eq("midright_strobes", 32'(n_strobes - s0), 32'd1);
    check_eq("midright_sample_l", sample_l, 32'h007FFFFF);
    check_eq("midright_sample_r", sample_r, 32'hFF800000);
  endtask

  task automatic test_frame_err();
    int s0, f0;
    s0 = n_strobes;
    f0 = n_ferr;
    send_word(1'b0, 24'hABCDEF, 10, 1'b0);
    send_word(1'b1, 24'h111111, 24, 1'b1);
    check_eq("ferr_count", 32'(n_ferr - f0), 32'd1);
    check_eq("ferr_no_strobe", 32'(n_strobes - s0), 32'd0);
    send_frame(24'h0A0B0C, 24'hF0F0F0, 1'b1);
    check_eq("ferr_recover_strobes", 32'(n_strobes - s0), 32'd1);
  endtask

  task automatic test_enable();
    int s0;
    send_frame(24'h000001, 24'h000002, 1'b1);
    send_frame(24'h222222, 24'hCCCCCC, 1'b1);
    s0 = n_strobes;
    send_word(1'b0, 24'h333333, 24, 1'b1);
    en = 1'b0;
    send_word(1'b1, 24'h444444, 24, 1'b1);
    check_eq("en_off_strobes", 32'(n_strobes - s0), 32'd0);
    check_eq("en_off_hold_l", sample_l, 32'h00222222);
    check_eq("en_off_hold_r", sample_r, 32'hFFCCCCCC);
    en = 1'b1;
    send_frame(24'h555555, 24'h666666, 1'b1);
    send_frame(24'h987654, 24'h00ABCD, 1'b1);
    check_eq("en_on_strobes", 32'(n_strobes - s0), 32'd2);
    check_eq("en_on_sample_l", sample_l, 32'hFF987654);
  endtask

  task automatic test_reset_mid_word();
    int s0;
    send_word(1'b0, 24'h5A5A5A, 12, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("rstmid_sample_l", sample_l, 32'h0);
    check_eq("rstmid_sample_r", sample_r, 32'h0);
    check_eq("rstmid_ready", {31'h0, audio_ready}, 32'h0);
    #39;
    rst = 1'b1;
    s0 = n_strobes;
    send_word(1'b1, 24'h777777, 24, 1'b1);
    send_frame(24'h13579B, 24'hECA864, 1'b1);
    check_eq("rstmid_strobes", 32'(n_strobes - s0), 32'd1);
    check_eq("rstmid_sample_r", sample_r, 32'hFFECA864);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_mid_right_start();
    test_frame_err();
    test_enable();
    test_reset_mid_word();
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
